uart_rx: RTL and testbench

// - Serial receiver for the 8N1 UART link; pairs with the design's uart_tx (same bit timing, LSB-first).
// - Oversamples RX at CLKS_PER_BIT clocks/bit, samples each bit at its midpoint, and reports each byte with a one-cycle strobe.
// - Packs WORD_BYTES consecutive bytes into one wide word for the host-side datapath (e.g. 32 bytes -> 256 bits).

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_word_pack.sv | 68 ++++++
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 frame constants, default bit timing and the
// receive/transmit FSM state encoding used by uart_rx and uart_tx.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4
    } uart_state_e;

    // Index width for a table of n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_word_pack.sv
// Packs consecutive good bytes into a WORD_BYTES-wide word. Partial bytes
// live in a shadow register; the visible word only changes on word_dv_o.
module uart_rx_word_pack
    import uart_pkg::*;
#(
    parameter int WORD_BYTES = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    byte_vld_i,
    input  logic [7:0]              byte_i,
    input  logic                    frame_err_i,
    input  logic                    word_clr_i,
    output logic                    word_dv_o,
    output logic [8*WORD_BYTES-1:0] word_o
);

    localparam int             IDX_W    = idx_width(WORD_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [WORD_BYTES-1:0][7:0]  shadow_q, shadow_d;
    logic [8*WORD_BYTES-1:0]     word_q, word_d;
    logic                        word_dv_q, word_dv_d;

    // Next-state: a clear (or a broken frame) resets the slot index and beats a
    // simultaneous good byte; otherwise the byte lands in its slot and the
    // last slot publishes the whole word.
    always_comb begin
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        word_d    = word_q;
        word_dv_d = 1'b0;
        if (word_clr_i || frame_err_i) begin
            idx_d = '0;
        end else if (byte_vld_i) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (IDX_W'(k) == idx_q) shadow_d[k] = byte_i;
            end
            if (idx_q == LAST_IDX) begin
                word_d    = shadow_d;
                word_dv_d = 1'b1;
                idx_d     = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Packing state and registered word outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            idx_q     <= '0;
            shadow_q  <= '0;
            word_q    <= '0;
            word_dv_q <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            word_q    <= word_d;
            word_dv_q <= word_dv_d;
        end
    end

    assign word_dv_o = word_dv_q;
    assign word_o    = word_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling FSM and a
// byte-to-word packer for the wide host datapath.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int WORD_BYTES   = 32
) (
    input  logic                    i_Clock,
    input  logic                    i_Rst_n,
    input  logic                    i_Rx_Serial,
    input  logic                    i_Word_Clr,
    output logic                    o_Rx_DV,
    output logic [7:0]              o_Rx_Byte,
    output logic                    o_Word_DV,
    output logic [8*WORD_BYTES-1:0] o_Rx_Word,
    output logic                    o_Frame_Err,
    output logic                    o_Rx_Active
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] MID_CNT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    logic              rx_meta_q, rx_sync_q;
    uart_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_idx_q;
    logic [7:0]        shift_q;
    logic [7:0]        byte_q;
    logic              dv_q, ferr_q, active_q;

    logic              bit_done;
    logic              stop_good, stop_bad;

    assign bit_done  = (cnt_q == LAST_CNT);
    assign stop_good = (state_q == ST_STOP) && bit_done &&  rx_sync_q;
    assign stop_bad  = (state_q == ST_STOP) && bit_done && !rx_sync_q;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx_Serial;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Frame FSM: validate start at half a bit, then sample every full bit.
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            dv_q   <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (!rx_sync_q) state_q <= ST_START;
                end
                ST_START: begin
                    if (cnt_q == MID_CNT) begin
                        cnt_q <= '0;
                        if (!rx_sync_q) begin
                            active_q <= 1'b1;
                            state_q  <= ST_DATA;
                        end else begin
                            state_q <= ST_IDLE;  // glitch shorter than half a bit
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_sync_q;
                        if (bit_idx_q == LAST_BIT) begin
                            bit_idx_q <= '0;
                            state_q   <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_done) begin
                        cnt_q <= '0;
                        if (rx_sync_q) begin
                            byte_q <= shift_q;
                            dv_q   <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        active_q <= 1'b0;
                        state_q  <= ST_CLEANUP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CLEANUP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    uart_rx_word_pack #(
        .WORD_BYTES (WORD_BYTES)
    ) u_word_pack (
        .clk_i       (i_Clock),
        .rst_ni      (i_Rst_n),
        .byte_vld_i  (stop_good),
        .byte_i      (shift_q),
        .frame_err_i (stop_bad),
        .word_clr_i  (i_Word_Clr),
        .word_dv_o   (o_Word_DV),
        .word_o      (o_Rx_Word)
    );

    assign o_Rx_DV     = dv_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Frame_Err = ferr_q;
    assign o_Rx_Active = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven by a bit-level transmitter task,
// checked by a monitor against a queue-based byte/word reference model.
module tb_uart_rx;

    localparam int CPB = 8;
    localparam int WB  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx = 1'b1;
    logic              clr = 1'b0;
    logic              o_Rx_DV, o_Word_DV, o_Frame_Err, o_Rx_Active;
    logic [7:0]        o_Rx_Byte;
    logic [8*WB-1:0]   o_Rx_Word;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(CPB), .WORD_BYTES(WB)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_Serial (rx),
        .i_Word_Clr  (clr),
        .o_Rx_DV     (o_Rx_DV),
        .o_Rx_Byte   (o_Rx_Byte),
        .o_Word_DV   (o_Word_DV),
        .o_Rx_Word   (o_Rx_Word),
        .o_Frame_Err (o_Frame_Err),
        .o_Rx_Active (o_Rx_Active)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected-byte stream: written by the stimulus, consumed by the monitor.
    logic [7:0] exp_mem [0:255];
    int wr_ptr = 0, ferr_sent = 0;

    // Monitor-owned model state and event counters.
    int         rd_ptr = 0, ferr_seen = 0, dv_cnt = 0, word_cnt = 0, act_cnt = 0;
    logic [7:0] packed_q [$];
    logic [63:0] exp_word = '0;
    logic       clr_e = 1'b0, rst_e = 1'b0;

    // Remember what the DUT saw on the clock edge that produced the outputs.
    always @(posedge clk) begin
        clr_e <= clr;
        rst_e <= rst_n;
    end

    // Reference model: compare every strobe against the expected stream and
    // rebuild words from plain byte lists.
    always @(negedge clk) begin : mon
        logic [7:0]  b;
        logic [63:0] w;
        if (!rst_e) begin
            packed_q.delete();
            exp_word = '0;
        end else begin
            if (o_Rx_Active) act_cnt++;
            if (o_Rx_DV && o_Frame_Err) chk("strobe_overlap", {o_Rx_DV, o_Frame_Err}, 2'b10);
            if (o_Word_DV && !o_Rx_DV) chk("word_dv_alone", o_Word_DV, 0);
            if (o_Rx_DV) begin
                dv_cnt++;
                if (o_Word_DV) word_cnt++;
                if (rd_ptr == wr_ptr) begin
                    chk("spurious_rx_dv", o_Rx_DV, 0);
                end else begin
                    b = exp_mem[rd_ptr[7:0]];
                    rd_ptr++;
                    chk("rx_byte", o_Rx_Byte, b);
                    chk("rx_active_at_dv", o_Rx_Active, 0);
                    if (clr_e) begin
                        packed_q.delete();
                        chk("word_dv_on_clr", o_Word_DV, 0);
                    end else begin
                        packed_q.push_back(b);
                        if (packed_q.size() == WB) begin
                            w = '0;
                            foreach (packed_q[k]) w |= 64'(packed_q[k]) << (8 * k);
                            exp_word = w;
                            packed_q.delete();
                            chk("word_dv", o_Word_DV, 1);
                        end else begin
                            chk("word_dv", o_Word_DV, 0);
                        end
                    end
                    chk("rx_word", o_Rx_Word, exp_word);
                end
            end else if (o_Frame_Err) begin
                chk("frame_err_expected", ferr_seen < ferr_sent, 1);
                ferr_seen++;
                packed_q.delete();
            end else if (clr_e) begin
                packed_q.delete();
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) begin
            exp_mem[wr_ptr[7:0]] = b;
            wr_ptr++;
        end else begin
            ferr_sent++;
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_dv"},     o_Rx_DV, 0);
        chk({tag, "_byte"},   o_Rx_Byte, 0);
        chk({tag, "_wdv"},    o_Word_DV, 0);
        chk({tag, "_word"},   o_Rx_Word, 0);
        chk({tag, "_ferr"},   o_Frame_Err, 0);
        chk({tag, "_active"}, o_Rx_Active, 0);
    endtask

    initial begin : stim
        int d0, f0, a0, w0;
        logic [7:0] rb;
        bit good;
        int mode;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(4);

        // Single byte
        f0 = ferr_seen;
        send_byte(8'hA5, 1);
        idle(3);
        chk("byte_a5", o_Rx_Byte, 8'hA5);
        chk("a5_no_ferr", ferr_seen - f0, 0);

        // Four bytes back-to-back form a word
        pulse_clr();
        w0 = word_cnt;
        send_byte(8'h11, 1); send_byte(8'h22, 1);
        send_byte(8'h33, 1); send_byte(8'h44, 1);
        idle(3);
        chk("word_44332211", o_Rx_Word, 64'h44332211);
        chk("word_cnt_1", word_cnt - w0, 1);

        // Short low glitch on an idle line
        d0 = dv_cnt; f0 = ferr_seen; a0 = act_cnt;
        rx = 1'b0; idle(2); rx = 1'b1;
        idle(3 * CPB);
        chk("glitch_dv", dv_cnt - d0, 0);
        chk("glitch_ferr", ferr_seen - f0, 0);
        chk("glitch_active", act_cnt - a0, 0);

        // Broken stop bit, then a full word
        d0 = dv_cnt; f0 = ferr_seen;
        send_byte(8'h3C, 0);
        idle(3 * CPB);
        chk("ferr_cnt", ferr_seen - f0, 1);
        chk("ferr_no_dv", dv_cnt - d0, 0);
        send_byte(8'h10, 1); send_byte(8'h20, 1);
        send_byte(8'h30, 1); send_byte(8'h40, 1);
        idle(3);
        chk("word_after_ferr", o_Rx_Word, 64'h40302010);

        // Clear pulse discards a partial word
        send_byte(8'h01, 1); send_byte(8'h02, 1);
        pulse_clr();
        send_byte(8'hAA, 1); send_byte(8'hBB, 1);
        send_byte(8'hCC, 1); send_byte(8'hDD, 1);
        idle(3);
        chk("word_ddccbbaa", o_Rx_Word, 64'hDDCCBBAA);

        // Clear held across a good byte: byte reported but not packed
        d0 = dv_cnt;
        send_byte(8'h01, 1); send_byte(8'h02, 1);
        clr = 1'b1;
        send_byte(8'h99, 1);
        clr = 1'b0;
        send_byte(8'h12, 1); send_byte(8'h34, 1);
        send_byte(8'h56, 1); send_byte(8'h78, 1);
        idle(3);
        chk("clr_dv_cnt", dv_cnt - d0, 7);
        chk("word_78563412", o_Rx_Word, 64'h78563412);

        // Reset in the middle of 0x5A's data bits
        send_byte(8'h01, 1);
        drive_bit(1'b0); drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("midreset");
        @(posedge clk); #2;
        rx = 1'b1;
        idle(1);
        rst_n = 1'b1;
        idle(2 * CPB);
        d0 = dv_cnt;
        send_byte(8'h77, 1);
        idle(3);
        chk("post_reset_dv_cnt", dv_cnt - d0, 1);
        chk("byte_77", o_Rx_Byte, 8'h77);

        // Randomized traffic with occasional errors and clears
        for (int i = 0; i < 40; i++) begin
            rb   = 8'($urandom);
            good = ($urandom_range(0, 7) != 0);
            mode = $urandom_range(0, 9);
            if (mode == 0) pulse_clr();
            if (mode == 1) clr = 1'b1;
            send_byte(rb, good);
            clr = 1'b0;
            if (!good) idle(3 * CPB);
            else       idle($urandom_range(0, 2 * CPB));
        end

        idle(4 * CPB);
        chk("all_bytes_seen", rd_ptr, wr_ptr);
        chk("all_ferr_seen", ferr_seen, ferr_sent);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
